// File: rtl/pipe_pkg.sv
// Shared types for the decode-stage hazard controller.
// Optional feature macro: ID_FORWARD_EN (EX-stage operand forwarding).
package pipe_pkg;

  // Architectural zero register; never a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // EX operand source; named after where the producer sits once the consumer is in EX
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_RET = 2'b11
  } fwd_sel_e;

  // Shadow of one in-flight instruction's destination state
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } hz_slot_t;

  localparam hz_slot_t SLOT_EMPTY = '{valid: 1'b0, rd: REG_ZERO, reg_write: 1'b0, mem_read: 1'b0};

  // True when the slot holds a live writer of register src
  function automatic logic slot_hit(hz_slot_t slot, logic [4:0] src);
    return slot.valid && slot.reg_write && (slot.rd == src);
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage hazard interface: instruction fields in, pipeline controls out.
// master = pipeline/decode side, slave = hazard controller.
interface id_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 32
);

  // Decoding instruction and pipeline context
  logic                   id_valid;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic [4:0]             id_rd;
  logic                   id_reg_write;
  logic                   id_mem_read;
  logic                   ex_branch_taken;
  logic                   ext_stall;

  // Front-end sequencing and forwarding
  logic                   stall_id;
  logic                   bubble_ex;
  logic                   flush_if_id;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output id_rd, id_reg_write, id_mem_read, ex_branch_taken, ext_stall,
    input  stall_id, bubble_ex, flush_if_id, fwd_a, fwd_b, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  id_rd, id_reg_write, id_mem_read, ex_branch_taken, ext_stall,
    output stall_id, bubble_ex, flush_if_id, fwd_a, fwd_b, stall_cycles
  );

endinterface

// File: rtl/hazard_match.sv
// Compares one decode source register against the EX/MEM/WB shadow slots.
// hits is ordered {wb, mem, ex}; fwd_sel picks the youngest matching producer.
module hazard_match
  import pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] src,
  input  logic       uses,
  input  hz_slot_t   ex_slot,
  input  hz_slot_t   mem_slot,
  input  hz_slot_t   wb_slot,
  output logic [2:0] hits,
  output fwd_sel_e   fwd_sel
);

  logic src_live;
  logic unused_mem_read;

  // x0 and unread operands can never depend on anything
  assign src_live = id_valid && uses && (src != REG_ZERO);

  // Load flags are judged by the parent, not here
  assign unused_mem_read = ^{ex_slot.mem_read, mem_slot.mem_read, wb_slot.mem_read};

  // Per-slot dependency check
  always_comb begin
    hits[0] = src_live && slot_hit(ex_slot, src);
    hits[1] = src_live && slot_hit(mem_slot, src);
    hits[2] = src_live && slot_hit(wb_slot, src);
  end

  // Youngest producer holds the freshest value, so it wins
  always_comb begin
    fwd_sel = FWD_RF;
    if (hits[0]) begin
      fwd_sel = FWD_MEM;
    end else if (hits[1]) begin
      fwd_sel = FWD_WB;
    end else if (hits[2]) begin
      fwd_sel = FWD_RET;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller for the 5-stage RV32 pipeline.
// Tracks destination state of EX/MEM/WB, raises stall/bubble/flush and,
// when ID_FORWARD_EN is defined, registers per-operand forwarding selects.
// Without ID_FORWARD_EN any in-flight producer stalls and fwd_a/fwd_b read 00.
module id_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  id_hazard_ctrl_if.slave  hz
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  hz_slot_t               ex_slot_reg;
  hz_slot_t               mem_slot_reg;
  hz_slot_t               wb_slot_reg;
  hz_slot_t               ex_slot_next;
  logic [STALL_CNT_W-1:0] stall_cycles_reg;

  logic [4:0]             src_idx   [2];
  logic                   src_uses  [2];
  logic [2:0]             src_hits  [2];
  fwd_sel_e               src_sel   [2];
  logic [1:0]             src_hazard;

  logic                   hazard;
  logic                   advance;
  logic                   cnt_inc;
  logic                   stall_id;
  logic                   bubble_ex;
  logic                   flush_if_id;

  assign src_idx[0]  = hz.id_rs1;
  assign src_idx[1]  = hz.id_rs2;
  assign src_uses[0] = hz.id_uses_rs1;
  assign src_uses[1] = hz.id_uses_rs2;

  // One comparator per source operand
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      hazard_match u_match (
        .id_valid (hz.id_valid),
        .src      (src_idx[gi]),
        .uses     (src_uses[gi]),
        .ex_slot  (ex_slot_reg),
        .mem_slot (mem_slot_reg),
        .wb_slot  (wb_slot_reg),
        .hits     (src_hits[gi]),
        .fwd_sel  (src_sel[gi])
      );
`ifdef ID_FORWARD_EN
      // Only a load still in EX cannot be forwarded in time
      assign src_hazard[gi] = |(src_hits[gi] & {2'b00, ex_slot_reg.mem_read});
`else
      // No bypass: wait until the producer has left WB
      assign src_hazard[gi] = |src_hits[gi];
`endif
    end
  endgenerate

  assign hazard  = |src_hazard;
  assign advance = !hz.ext_stall;

  // Front-end control: external freeze, then redirect, then hazard
  always_comb begin
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    if (hz.ext_stall) begin
      stall_id = 1'b1;
    end else if (hz.ex_branch_taken) begin
      flush_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end else if (hazard) begin
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  // What enters EX on an advance: the decoding instruction or a bubble
  always_comb begin
    ex_slot_next = SLOT_EMPTY;
    if (!bubble_ex) begin
      ex_slot_next.valid     = hz.id_valid;
      ex_slot_next.rd        = hz.id_rd;
      ex_slot_next.reg_write = hz.id_reg_write;
      ex_slot_next.mem_read  = hz.id_mem_read;
    end
  end

  // Shadow slots shift together and freeze under ext_stall
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_slot_reg  <= SLOT_EMPTY;
      mem_slot_reg <= SLOT_EMPTY;
      wb_slot_reg  <= SLOT_EMPTY;
    end else if (advance) begin
      wb_slot_reg  <= mem_slot_reg;
      mem_slot_reg <= ex_slot_reg;
      ex_slot_reg  <= ex_slot_next;
    end
  end

  // A hazard cycle is one where ID is held and a bubble is inserted
  assign cnt_inc = advance && !hz.ex_branch_taken && hazard;

  // Saturating hazard-stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg <= '0;
    end else if (cnt_inc && (stall_cycles_reg != CNT_MAX)) begin
      stall_cycles_reg <= stall_cycles_reg + CNT_ONE;
    end
  end

  assign hz.stall_id     = stall_id;
  assign hz.bubble_ex    = bubble_ex;
  assign hz.flush_if_id  = flush_if_id;
  assign hz.stall_cycles = stall_cycles_reg;

`ifdef ID_FORWARD_EN
  fwd_sel_e fwd_a_reg;
  fwd_sel_e fwd_b_reg;

  // Selects travel with the instruction into EX; a bubble reads the regfile
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_reg <= FWD_RF;
      fwd_b_reg <= FWD_RF;
    end else if (advance) begin
      fwd_a_reg <= bubble_ex ? FWD_RF : src_sel[0];
      fwd_b_reg <= bubble_ex ? FWD_RF : src_sel[1];
    end
  end

  assign hz.fwd_a = fwd_a_reg;
  assign hz.fwd_b = fwd_b_reg;
`else
  logic unused_fwd_sel;

  // Operands always come from the regfile in this build
  assign unused_fwd_sel = ^{src_sel[0], src_sel[1]};
  assign hz.fwd_a       = FWD_RF;
  assign hz.fwd_b       = FWD_RF;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed vector table, corner sequences and a
// randomized run against an in-flight-list reference model.
// Works with and without ID_FORWARD_EN defined.
`timescale 1ns/1ps
module tb_id_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CW = 32;
  localparam longint CNT_MAX = (64'd1 << CW) - 1;
`ifdef ID_FORWARD_EN
  localparam int EXP_LOAD_STALL = 1;
  localparam int EXP_FWD_AFTER  = 2;
`else
  localparam int EXP_LOAD_STALL = 3;
  localparam int EXP_FWD_AFTER  = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_hazard_ctrl_if #(.STALL_CNT_W(CW)) hz ();

  id_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // Every instruction that has left ID, with its age: 1 = EX, 2 = MEM, 3 = WB
  typedef struct {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    int         age;
  } flight_t;

  flight_t    inflight [$];
  logic [1:0] m_fa = 2'd0;
  logic [1:0] m_fb = 2'd0;
  longint     m_cnt = 0;

  function automatic bit reads(logic [4:0] src, logic u, logic [4:0] rd);
    return hz.id_valid && u && (src != 5'd0) && (src == rd);
  endfunction

  // Age of the youngest in-flight writer of src, 0 when none
  function automatic int youngest(logic [4:0] src, logic u);
    int best = 0;
    foreach (inflight[i]) begin
      if (inflight[i].wr && reads(src, u, inflight[i].rd) &&
          (best == 0 || inflight[i].age < best))
        best = inflight[i].age;
    end
    return best;
  endfunction

  function automatic bit model_hazard();
    bit h = 0;
    foreach (inflight[i]) begin
      bit dep;
      dep = inflight[i].wr &&
            (reads(hz.id_rs1, hz.id_uses_rs1, inflight[i].rd) ||
             reads(hz.id_rs2, hz.id_uses_rs2, inflight[i].rd));
`ifdef ID_FORWARD_EN
      dep = dep && inflight[i].ld && (inflight[i].age == 1);
`endif
      if (dep) h = 1;
    end
    return h;
  endfunction

  task automatic model_comb(output logic st, output logic bu, output logic fo);
    st = 1'b0; bu = 1'b0; fo = 1'b0;
    if (hz.ext_stall) st = 1'b1;
    else if (hz.ex_branch_taken) begin bu = 1'b1; fo = 1'b1; end
    else if (model_hazard()) begin st = 1'b1; bu = 1'b1; end
  endtask

  // Apply one clock edge to the model using the inputs present at the edge
  task automatic model_step();
    logic st, bu, fo;
`ifdef ID_FORWARD_EN
    int sa, sb;
`endif
    if (reset) begin
      inflight.delete();
      m_fa = 2'd0; m_fb = 2'd0; m_cnt = 0;
      return;
    end
    if (hz.ext_stall) return;
    model_comb(st, bu, fo);
`ifdef ID_FORWARD_EN
    sa = youngest(hz.id_rs1, hz.id_uses_rs1);
    sb = youngest(hz.id_rs2, hz.id_uses_rs2);
    m_fa = bu ? 2'd0 : 2'(sa);
    m_fb = bu ? 2'd0 : 2'(sb);
`endif
    foreach (inflight[i]) inflight[i].age++;
    for (int i = inflight.size() - 1; i >= 0; i--)
      if (inflight[i].age > 3) inflight.delete(i);
    if (!bu && hz.id_valid)
      inflight.push_back('{rd: hz.id_rd, wr: hz.id_reg_write, ld: hz.id_mem_read, age: 1});
    if (st && bu && m_cnt < CNT_MAX) m_cnt++;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br, input logic xs);
    hz.id_valid = v; hz.id_rs1 = r1; hz.id_uses_rs1 = u1;
    hz.id_rs2 = r2; hz.id_uses_rs2 = u2; hz.id_rd = rd;
    hz.id_reg_write = rw; hz.id_mem_read = mr;
    hz.ex_branch_taken = br; hz.ext_stall = xs;
  endtask

  task automatic model_check(string tag);
    logic st, bu, fo;
    model_comb(st, bu, fo);
    chk({tag, ".stall_id"}, 64'(hz.stall_id), 64'(st));
    chk({tag, ".bubble_ex"}, 64'(hz.bubble_ex), 64'(bu));
    chk({tag, ".flush_if_id"}, 64'(hz.flush_if_id), 64'(fo));
    chk({tag, ".fwd_a"}, 64'(hz.fwd_a), 64'(m_fa));
    chk({tag, ".fwd_b"}, 64'(hz.fwd_b), 64'(m_fb));
    chk({tag, ".stall_cycles"}, 64'(hz.stall_cycles), 64'(m_cnt));
    $display("%s: st=%0b bu=%0b fl=%0b fa=%0d fb=%0d cnt=%0d", tag, hz.stall_id,
             hz.bubble_ex, hz.flush_if_id, hz.fwd_a, hz.fwd_b, hz.stall_cycles);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(string tag);
    @(negedge clk);
    model_check(tag);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    cyc("reset");
    reset = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       v;
    logic [4:0] r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic [4:0] rd;
    logic       rw, mr, br, xs;
    logic       e_st, e_bu, e_fl;
    logic [1:0] e_fa, e_fb;
    int         e_cnt;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic v, logic [4:0] r1, logic u1, logic [4:0] r2, logic u2,
                              logic [4:0] rd, logic rw, logic mr, logic br, logic xs,
                              logic st, logic bu, logic fl, logic [1:0] fa, logic [1:0] fb,
                              int cnt);
    vec_t t;
    t.v = v; t.r1 = r1; t.u1 = u1; t.r2 = r2; t.u2 = u2; t.rd = rd;
    t.rw = rw; t.mr = mr; t.br = br; t.xs = xs;
    t.e_st = st; t.e_bu = bu; t.e_fl = fl; t.e_fa = fa; t.e_fb = fb; t.e_cnt = cnt;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    logic got;

    // Rows: producer/consumer pairs, x0 and unused-source cases, branch over load-use
`ifdef ID_FORWARD_EN
    tbl.push_back(mk(1, 1,1, 2,1,  5,1,0, 0,0,  0,0,0, 0,0, 0)); // add x5
    tbl.push_back(mk(1, 5,1, 3,1,  7,1,0, 0,0,  0,0,0, 0,0, 0)); // add rs1=x5: bypass
    tbl.push_back(mk(0, 0,0, 0,0,  0,0,0, 0,0,  0,0,0, 1,0, 0)); // fwd_a=01
    tbl.push_back(mk(1, 2,1, 0,0,  6,1,1, 0,0,  0,0,0, 0,0, 0)); // lw x6
    tbl.push_back(mk(1, 1,1, 6,1,  8,1,0, 0,0,  1,1,0, 0,0, 0)); // load-use stall
    tbl.push_back(mk(1, 1,1, 6,1,  8,1,0, 0,0,  0,0,0, 0,0, 1)); // advances
    tbl.push_back(mk(0, 0,0, 0,0,  0,0,0, 0,0,  0,0,0, 0,2, 1)); // fwd_b=10
    tbl.push_back(mk(1, 1,1, 2,1,  0,1,1, 0,0,  0,0,0, 0,0, 1)); // lw x0
    tbl.push_back(mk(1, 0,1, 0,1, 11,1,0, 0,0,  0,0,0, 0,0, 1)); // reads x0
    tbl.push_back(mk(1, 0,0, 0,0,  9,1,1, 0,0,  0,0,0, 0,0, 1)); // lw x9
    tbl.push_back(mk(1, 9,0, 3,1, 12,1,0, 0,0,  0,0,0, 0,0, 1)); // rs1 unused
    tbl.push_back(mk(1, 0,0, 0,0, 10,1,1, 0,0,  0,0,0, 0,0, 1)); // lw x10
    tbl.push_back(mk(1,10,1, 0,0, 13,1,0, 1,0,  0,1,1, 0,0, 1)); // flush beats hazard
    tbl.push_back(mk(0, 0,0, 0,0,  0,0,0, 0,0,  0,0,0, 0,0, 1));
`else
    tbl.push_back(mk(1, 1,1, 2,1,  5,1,0, 0,0,  0,0,0, 0,0, 0)); // add x5
    tbl.push_back(mk(1, 5,1, 3,1,  7,1,0, 0,0,  1,1,0, 0,0, 0)); // producer in EX
    tbl.push_back(mk(1, 5,1, 3,1,  7,1,0, 0,0,  1,1,0, 0,0, 1)); // in MEM
    tbl.push_back(mk(1, 5,1, 3,1,  7,1,0, 0,0,  1,1,0, 0,0, 2)); // in WB
    tbl.push_back(mk(1, 5,1, 3,1,  7,1,0, 0,0,  0,0,0, 0,0, 3)); // advances
    tbl.push_back(mk(0, 0,0, 0,0,  0,0,0, 0,0,  0,0,0, 0,0, 3));
    tbl.push_back(mk(1, 1,1, 2,1,  0,1,1, 0,0,  0,0,0, 0,0, 3)); // lw x0
    tbl.push_back(mk(1, 0,1, 0,1, 11,1,0, 0,0,  0,0,0, 0,0, 3)); // reads x0
    tbl.push_back(mk(1, 0,0, 0,0,  9,1,1, 0,0,  0,0,0, 0,0, 3)); // lw x9
    tbl.push_back(mk(1, 9,0, 3,1, 12,1,0, 0,0,  0,0,0, 0,0, 3)); // rs1 unused
    tbl.push_back(mk(1, 0,0, 0,0, 10,1,1, 0,0,  0,0,0, 0,0, 3)); // lw x10
    tbl.push_back(mk(1,10,1, 0,0, 13,1,0, 1,0,  0,1,1, 0,0, 3)); // flush beats hazard
    tbl.push_back(mk(0, 0,0, 0,0,  0,0,0, 0,0,  0,0,0, 0,0, 3));
`endif

    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].r1, tbl[i].u1, tbl[i].r2, tbl[i].u2, tbl[i].rd,
            tbl[i].rw, tbl[i].mr, tbl[i].br, tbl[i].xs);
      @(negedge clk);
      chk($sformatf("T%0d.stall_id", i), 64'(hz.stall_id), 64'(tbl[i].e_st));
      chk($sformatf("T%0d.bubble_ex", i), 64'(hz.bubble_ex), 64'(tbl[i].e_bu));
      chk($sformatf("T%0d.flush_if_id", i), 64'(hz.flush_if_id), 64'(tbl[i].e_fl));
      chk($sformatf("T%0d.fwd_a", i), 64'(hz.fwd_a), 64'(tbl[i].e_fa));
      chk($sformatf("T%0d.fwd_b", i), 64'(hz.fwd_b), 64'(tbl[i].e_fb));
      chk($sformatf("T%0d.stall_cycles", i), 64'(hz.stall_cycles), 64'(tbl[i].e_cnt));
      $display("T%0d: st=%0b bu=%0b fl=%0b fa=%0d fb=%0d cnt=%0d", i, hz.stall_id,
               hz.bubble_ex, hz.flush_if_id, hz.fwd_a, hz.fwd_b, hz.stall_cycles);
      tick();
    end

    // Sequence A: ext_stall held 4 cycles over a load-use dependency
    do_reset();
    drive(1, 2,1, 0,0, 6,1,1, 0,0);
    cyc("A.lw");
    drive(1, 1,1, 6,1, 8,1,0, 0,1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      model_check($sformatf("A.frozen%0d", k));
      chk("A.frozen_bubble", 64'(hz.bubble_ex), 64'd0);
      chk("A.frozen_cnt", 64'(hz.stall_cycles), 64'd0);
      tick();
    end
    hz.ext_stall = 1'b0;
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      model_check($sformatf("A.rel%0d", k));
      got = hz.stall_id;
      tick();
      if (!got) break;
      stalls++;
    end
    chk("A.stall_len", 64'(stalls), 64'(EXP_LOAD_STALL));
    drive(0, 0,0, 0,0, 0,0,0, 0,0);
    @(negedge clk);
    model_check("A.after");
    chk("A.fwd_b_after", 64'(hz.fwd_b), 64'(EXP_FWD_AFTER));
    chk("A.cnt_after", 64'(hz.stall_cycles), 64'(EXP_LOAD_STALL));
    tick();

    // Sequence B: branch held under ext_stall flushes only on release
    drive(1, 2,1, 0,0, 6,1,1, 0,0);
    cyc("B.lw");
    drive(1, 1,1, 6,1, 8,1,0, 1,1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      model_check($sformatf("B.held%0d", k));
      chk("B.held_flush", 64'(hz.flush_if_id), 64'd0);
      chk("B.held_stall", 64'(hz.stall_id), 64'd1);
      tick();
    end
    hz.ext_stall = 1'b0;
    @(negedge clk);
    model_check("B.release");
    chk("B.flush", 64'(hz.flush_if_id), 64'd1);
    chk("B.bubble", 64'(hz.bubble_ex), 64'd1);
    chk("B.no_stall", 64'(hz.stall_id), 64'd0);
    tick();
    drive(0, 0,0, 0,0, 0,0,0, 0,0);
    @(negedge clk);
    chk("B.cnt_kept", 64'(hz.stall_cycles), 64'(EXP_LOAD_STALL));
    model_check("B.after");
    tick();

    // Sequence C: reset lands in the middle of a load-use stall
    drive(1, 2,1, 0,0, 5,1,1, 0,0);
    cyc("C.lw");
    drive(1, 5,1, 0,0, 9,1,0, 0,0);
    reset = 1'b1;
    @(negedge clk);
    model_check("C.in_reset");
    chk("C.stall_in_reset", 64'(hz.stall_id), 64'd1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    model_check("C.post_reset");
    chk("C.stall_dropped", 64'(hz.stall_id), 64'd0);
    chk("C.cnt_cleared", 64'(hz.stall_cycles), 64'd0);
    chk("C.fwd_a_cleared", 64'(hz.fwd_a), 64'd0);
    tick();

    // Randomized traffic on a small register window to provoke dependencies
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(99) < 2);
      drive($urandom_range(9) != 0,
            5'($urandom_range(3)), 1'($urandom_range(1)),
            5'($urandom_range(3)), 1'($urandom_range(1)),
            5'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(2) == 0,
            $urandom_range(9) == 0, $urandom_range(4) == 0);
      cyc($sformatf("R%0d", k));
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
